q_capture: RTL

//  Downstream consumer of a bank of WIDTH q_flop bits; sits after the q_flop/q_clock pair.

---
 rtl/q_capture.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/q_capture.sv
// Captures one WIDTH-bit q_out word per all-ack completion into a 2-deep FIFO on a valid/ready port.
// Latency 1 clk capture->m_valid; stall while full, a word pushed while full with no pop is dropped (err_overrun).

module q_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] in_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full,
  output logic         push_drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CMAX);
  assign head_dat = mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module q_capture #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_out,
  input  logic [WIDTH-1:0] q_ack,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             stall,
  output logic             err_overrun,
  output logic             err_timeout
);
  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_timeout_q, err_timeout_d;
  logic       err_overrun_q, err_overrun_d;
  logic       all_ack, any_ack;
  logic       push, pop, fifo_empty, fifo_full, push_drop;

  assign all_ack = &q_ack;
  assign any_ack = |q_ack;
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    push          = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (all_ack) begin
          push    = 1'b1;
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (any_ack) begin
          // Saturate so a permanently stuck partial ack never wraps the counter.
          if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_MAX) err_timeout_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      S_HELD: begin
        cnt_d = '0;
        if (!any_ack) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign err_overrun_d = err_overrun_q || push_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_WAIT;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  q_fifo #(.W(WIDTH), .DEPTH(2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .in_dat    (q_out),
    .pop       (pop),
    .head_dat  (m_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .push_drop (push_drop)
  );

  assign m_valid     = !fifo_empty;
  assign stall       = fifo_full;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;
endmodule
